// File: rtl/exception_return_ctrl_if.sv
// Bus between the datapath/exception handler and the exception return controller.
// The master drives requests and the read select. The slave returns the latched state and PC redirect strobes.
interface exception_return_ctrl_if;
   logic        Exc_Req;
   logic        Exc_Type;
   logic [15:0] Faulting_PC;
   logic        Eret;
   logic        Read_Sel;
   logic [15:0] Read_Data;
   logic [15:0] EPC;
   logic        Cause;
   logic        Flush;
   logic        PC_Load;
   logic [15:0] PC_Next;
   logic        Busy;

   modport master (
      output Exc_Req, Exc_Type, Faulting_PC, Eret, Read_Sel,
      input  Read_Data, EPC, Cause, Flush, PC_Load, PC_Next, Busy
   );

   modport slave (
      input  Exc_Req, Exc_Type, Faulting_PC, Eret, Read_Sel,
      output Read_Data, EPC, Cause, Flush, PC_Load, PC_Next, Busy
   );
endinterface

// File: rtl/exception_return_ctrl.sv
// Exception capture and return controller. It latches EPC and Cause, flushes the pipeline and vectors to the handler.
// On ERET it reloads the PC from EPC+RET_INC.
module exception_return_ctrl #(
   parameter logic [15:0] VEC_OVF = 16'h0040,
   parameter logic [15:0] VEC_ILL = 16'h0080,
   parameter logic [15:0] RET_INC = 16'h0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   exception_return_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_VECTOR,
      S_HANDLER,
      S_RETURN
   } state_t;

   state_t      state_q;
   logic [15:0] epc_q;
   logic        cause_q;
   logic        overrun_q;
   logic        flush_q;
   logic        pc_load_q;
   logic [15:0] pc_next_q;
   logic        busy_q;

   logic [15:0] ret_pc_d;
   logic [15:0] vec_pc_d;

   // The return address wraps modulo 2^16 (FFFF+1 -> 0000).
   assign ret_pc_d = epc_q + RET_INC;
   assign vec_pc_d = cause_q ? VEC_ILL : VEC_OVF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         epc_q     <= 16'h0000;
         cause_q   <= 1'b0;
         overrun_q <= 1'b0;
         flush_q   <= 1'b0;
         pc_load_q <= 1'b0;
         pc_next_q <= 16'h0000;
         busy_q    <= 1'b0;
      end else begin
         flush_q   <= 1'b0;
         pc_load_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.Exc_Req) begin
                  epc_q   <= bus.Faulting_PC;
                  cause_q <= bus.Exc_Type;
                  flush_q <= 1'b1;
                  state_q <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               pc_load_q <= 1'b1;
               pc_next_q <= vec_pc_d;
               state_q   <= S_VECTOR;
            end
            S_VECTOR: begin
               busy_q  <= 1'b1;
               state_q <= S_HANDLER;
            end
            S_HANDLER: begin
               // ERET has priority over a nested request. Overrun is cleared on the way out.
               if (bus.Eret) begin
                  pc_load_q <= 1'b1;
                  pc_next_q <= ret_pc_d;
                  busy_q    <= 1'b0;
                  overrun_q <= 1'b0;
                  state_q   <= S_RETURN;
               end else if (bus.Exc_Req) begin
                  overrun_q <= 1'b1;
               end
            end
            S_RETURN: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.EPC       = epc_q;
   assign bus.Cause     = cause_q;
   assign bus.Flush     = flush_q;
   assign bus.PC_Load   = pc_load_q;
   assign bus.PC_Next   = pc_next_q;
   assign bus.Busy      = busy_q;
   assign bus.Read_Data = bus.Read_Sel ? {14'b0, overrun_q, cause_q} : epc_q;

endmodule

// File: tb/tb_exception_return_ctrl.sv
// Directed testbench for exception_return_ctrl. Each task drives one scenario and checks hand-computed values.
module tb_exception_return_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   exception_return_ctrl_if bus ();

   exception_return_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flush and PC_Load must never be high in the same cycle.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (bus.Flush === 1'b1 && bus.PC_Load === 1'b1) begin
            $display("FAIL flush_pcload_overlap: got Flush=%0b PC_Load=%0b want not both 1", bus.Flush, bus.PC_Load);
            errors++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.Exc_Req = 1'b0; bus.Exc_Type = 1'b0; bus.Faulting_PC = 16'h0000;
      bus.Eret = 1'b0; bus.Read_Sel = 1'b0;
      #2;
      checks++; if (bus.Busy !== 1'b0 || bus.PC_Load !== 1'b0 || bus.Flush !== 1'b0) begin $display("FAIL reset_strobes: got Busy=%0b PC_Load=%0b Flush=%0b want 0 0 0", bus.Busy, bus.PC_Load, bus.Flush); errors++; end
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (bus.EPC !== 16'h0000) begin $display("FAIL idle_epc: got %h want 0000", bus.EPC); errors++; end
      checks++; if (bus.Cause !== 1'b0 || bus.Busy !== 1'b0) begin $display("FAIL idle_cause_busy: got Cause=%0b Busy=%0b want 0 0", bus.Cause, bus.Busy); errors++; end
      checks++; if (bus.Flush !== 1'b0 || bus.PC_Load !== 1'b0 || bus.PC_Next !== 16'h0000) begin $display("FAIL idle_pc: got Flush=%0b PC_Load=%0b PC_Next=%h want 0 0 0000", bus.Flush, bus.PC_Load, bus.PC_Next); errors++; end
      checks++; if (bus.Read_Data !== 16'h0000) begin $display("FAIL idle_read0: got %h want 0000", bus.Read_Data); errors++; end
      bus.Read_Sel = 1'b1; #1;
      checks++; if (bus.Read_Data !== 16'h0000) begin $display("FAIL idle_read1: got %h want 0000", bus.Read_Data); errors++; end
      bus.Read_Sel = 1'b0;
      // Eret in IDLE must be ignored.
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Load !== 1'b0 || bus.Busy !== 1'b0) begin $display("FAIL idle_eret: got PC_Load=%0b Busy=%0b want 0 0", bus.PC_Load, bus.Busy); errors++; end
      tick();
   endtask

   task automatic test_overflow();
      bus.Exc_Type = 1'b0; bus.Faulting_PC = 16'hAB00; bus.Exc_Req = 1'b1;
      tick();
      bus.Exc_Req = 1'b0; bus.Faulting_PC = 16'h0000;
      checks++; if (bus.Flush !== 1'b1 || bus.PC_Load !== 1'b0) begin $display("FAIL ovf_flush: got Flush=%0b PC_Load=%0b want 1 0", bus.Flush, bus.PC_Load); errors++; end
      checks++; if (bus.EPC !== 16'hAB00 || bus.Cause !== 1'b0) begin $display("FAIL ovf_latch: got EPC=%h Cause=%0b want AB00 0", bus.EPC, bus.Cause); errors++; end
      checks++; if (bus.Read_Data !== 16'hAB00) begin $display("FAIL ovf_read0: got %h want AB00", bus.Read_Data); errors++; end
      checks++; if (bus.Busy !== 1'b0) begin $display("FAIL ovf_busy_n1: got %0b want 0", bus.Busy); errors++; end
      tick();
      checks++; if (bus.Flush !== 1'b0 || bus.PC_Load !== 1'b1 || bus.PC_Next !== 16'h0040) begin $display("FAIL ovf_vector: got Flush=%0b PC_Load=%0b PC_Next=%h want 0 1 0040", bus.Flush, bus.PC_Load, bus.PC_Next); errors++; end
      checks++; if (bus.Busy !== 1'b0) begin $display("FAIL ovf_busy_n2: got %0b want 0", bus.Busy); errors++; end
      tick();
      checks++; if (bus.Busy !== 1'b1 || bus.PC_Load !== 1'b0) begin $display("FAIL ovf_busy_n3: got Busy=%0b PC_Load=%0b want 1 0", bus.Busy, bus.PC_Load); errors++; end
      tick(); tick();
      checks++; if (bus.Busy !== 1'b1) begin $display("FAIL ovf_busy_hold: got %0b want 1", bus.Busy); errors++; end
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Load !== 1'b1 || bus.PC_Next !== 16'hAB01 || bus.Busy !== 1'b0) begin $display("FAIL ovf_return: got PC_Load=%0b PC_Next=%h Busy=%0b want 1 AB01 0", bus.PC_Load, bus.PC_Next, bus.Busy); errors++; end
      tick();
      checks++; if (bus.PC_Load !== 1'b0 || bus.Busy !== 1'b0) begin $display("FAIL ovf_after_ret: got PC_Load=%0b Busy=%0b want 0 0", bus.PC_Load, bus.Busy); errors++; end
   endtask

   task automatic test_illegal_nested();
      bus.Exc_Type = 1'b1; bus.Faulting_PC = 16'h00CD; bus.Exc_Req = 1'b1;
      tick();
      bus.Exc_Req = 1'b0; bus.Exc_Type = 1'b0;
      checks++; if (bus.Flush !== 1'b1 || bus.Cause !== 1'b1) begin $display("FAIL ill_flush: got Flush=%0b Cause=%0b want 1 1", bus.Flush, bus.Cause); errors++; end
      tick();
      checks++; if (bus.PC_Load !== 1'b1 || bus.PC_Next !== 16'h0080) begin $display("FAIL ill_vector: got PC_Load=%0b PC_Next=%h want 1 0080", bus.PC_Load, bus.PC_Next); errors++; end
      tick();
      bus.Exc_Req = 1'b1; bus.Faulting_PC = 16'h1234;
      tick();
      bus.Exc_Req = 1'b0; bus.Faulting_PC = 16'h0000;
      checks++; if (bus.EPC !== 16'h00CD || bus.Cause !== 1'b1 || bus.Flush !== 1'b0) begin $display("FAIL ill_nested_latch: got EPC=%h Cause=%0b Flush=%0b want 00CD 1 0", bus.EPC, bus.Cause, bus.Flush); errors++; end
      bus.Read_Sel = 1'b1; #1;
      checks++; if (bus.Read_Data !== 16'h0003) begin $display("FAIL ill_overrun_status: got %h want 0003", bus.Read_Data); errors++; end
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Next !== 16'h00CE || bus.PC_Load !== 1'b1) begin $display("FAIL ill_return: got PC_Load=%0b PC_Next=%h want 1 00CE", bus.PC_Load, bus.PC_Next); errors++; end
      tick();
      checks++; if (bus.Read_Data !== 16'h0001) begin $display("FAIL ill_status_after: got %h want 0001", bus.Read_Data); errors++; end
      bus.Read_Sel = 1'b0;
   endtask

   task automatic test_wraparound();
      bus.Exc_Type = 1'b0; bus.Faulting_PC = 16'hFFFF; bus.Exc_Req = 1'b1;
      tick();
      bus.Exc_Req = 1'b0;
      tick(); tick(); tick();
      checks++; if (bus.EPC !== 16'hFFFF || bus.Busy !== 1'b1) begin $display("FAIL wrap_handler: got EPC=%h Busy=%0b want FFFF 1", bus.EPC, bus.Busy); errors++; end
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Load !== 1'b1 || bus.PC_Next !== 16'h0000) begin $display("FAIL wrap_return: got PC_Load=%0b PC_Next=%h want 1 0000", bus.PC_Load, bus.PC_Next); errors++; end
      tick();
   endtask

   task automatic test_back_to_back();
      bus.Exc_Type = 1'b0; bus.Faulting_PC = 16'h5555; bus.Exc_Req = 1'b1;
      tick();
      bus.Exc_Req = 1'b0;
      tick(); tick(); tick();
      bus.Exc_Req = 1'b1; bus.Faulting_PC = 16'h9999; bus.Eret = 1'b1;
      tick();
      bus.Eret = 1'b0;
      checks++; if (bus.PC_Load !== 1'b1 || bus.PC_Next !== 16'h5556 || bus.Busy !== 1'b0) begin $display("FAIL b2b_return: got PC_Load=%0b PC_Next=%h Busy=%0b want 1 5556 0", bus.PC_Load, bus.PC_Next, bus.Busy); errors++; end
      bus.Read_Sel = 1'b1; #1;
      checks++; if (bus.Read_Data !== 16'h0000) begin $display("FAIL b2b_overrun_clear: got %h want 0000", bus.Read_Data); errors++; end
      bus.Read_Sel = 1'b0;
      // Request held through the RETURN edge is ignored there and accepted on the next IDLE edge.
      bus.Exc_Type = 1'b1; bus.Faulting_PC = 16'h7777;
      tick();
      checks++; if (bus.Flush !== 1'b0 || bus.EPC !== 16'h5555) begin $display("FAIL b2b_return_ignore: got Flush=%0b EPC=%h want 0 5555", bus.Flush, bus.EPC); errors++; end
      tick();
      bus.Exc_Req = 1'b0;
      checks++; if (bus.Flush !== 1'b1 || bus.EPC !== 16'h7777 || bus.Cause !== 1'b1) begin $display("FAIL b2b_accept: got Flush=%0b EPC=%h Cause=%0b want 1 7777 1", bus.Flush, bus.EPC, bus.Cause); errors++; end
      tick(); tick();
      bus.Read_Sel = 1'b1; #1;
      checks++; if (bus.Read_Data !== 16'h0001 || bus.Busy !== 1'b1) begin $display("FAIL b2b_no_overrun: got Read_Data=%h Busy=%0b want 0001 1", bus.Read_Data, bus.Busy); errors++; end
      bus.Read_Sel = 1'b0;
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Next !== 16'h7778) begin $display("FAIL b2b_second_return: got %h want 7778", bus.PC_Next); errors++; end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.Exc_Type = 1'b1; bus.Faulting_PC = 16'h2222; bus.Exc_Req = 1'b1;
      tick();
      bus.Exc_Req = 1'b0;
      tick(); tick(); tick();
      checks++; if (bus.Busy !== 1'b1) begin $display("FAIL rstmid_pre_busy: got %0b want 1", bus.Busy); errors++; end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.Busy !== 1'b0 || bus.EPC !== 16'h0000 || bus.Cause !== 1'b0 || bus.PC_Load !== 1'b0) begin $display("FAIL rstmid_async: got Busy=%0b EPC=%h Cause=%0b PC_Load=%0b want 0 0000 0 0", bus.Busy, bus.EPC, bus.Cause, bus.PC_Load); errors++; end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.Eret = 1'b1; tick(); bus.Eret = 1'b0;
      checks++; if (bus.PC_Load !== 1'b0 || bus.Busy !== 1'b0 || bus.PC_Next !== 16'h0000) begin $display("FAIL rstmid_eret_ignored: got PC_Load=%0b Busy=%0b PC_Next=%h want 0 0 0000", bus.PC_Load, bus.Busy, bus.PC_Next); errors++; end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_overflow();
      test_illegal_nested();
      test_wraparound();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
